// File: rtl/anita3_phi_trigger_receiver.sv
// Phi-sector trigger receiver: edge detect, per-sector coincidence windows,
// adjacent-sector (L2) coincidence with wrap-around, and a holdoff trigger FSM.
module anita3_phi_trigger_receiver #(
  parameter int NUM_PHI      = 16,
  parameter int STRETCH_BITS = 4,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    clk250_i,
  input  logic                    rst_i,
  input  logic [NUM_PHI-1:0]      V_pol_phi_i,
  input  logic [NUM_PHI-1:0]      H_pol_phi_i,
  input  logic [STRETCH_BITS-1:0] stretch_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [1:0]              pol_mode_i,
  output logic                    trig_o,
  output logic [NUM_PHI-1:0]      trig_phi_o,
  output logic [1:0]              trig_pol_o,
  output logic                    busy_o,
  output logic [15:0]             trig_count_o
);

  localparam logic [STRETCH_BITS-1:0] CNT_ZERO  = {STRETCH_BITS{1'b0}};
  localparam logic [STRETCH_BITS-1:0] CNT_ONE   = {{(STRETCH_BITS-1){1'b0}}, 1'b1};
  localparam logic [HOLDOFF_BITS-1:0] HOLD_ZERO = {HOLDOFF_BITS{1'b0}};
  localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE  = {{(HOLDOFF_BITS-1){1'b0}}, 1'b1};
  localparam logic [NUM_PHI-1:0]      PHI_ZERO  = {NUM_PHI{1'b0}};

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    TRIGGER = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  logic [NUM_PHI-1:0]      in_v_r, in_h_r, prev_v_r, prev_h_r;
  logic [NUM_PHI-1:0]      edge_v_r, edge_h_r;
  logic [STRETCH_BITS-1:0] cnt_v_r [NUM_PHI];
  logic [STRETCH_BITS-1:0] cnt_h_r [NUM_PHI];
  logic [NUM_PHI-1:0]      win_v, win_h;
  logic [NUM_PHI-1:0]      pair_v_r, pair_h_r;
  logic                    v_en, h_en, v_fire, h_fire, sel;
  state_t                  state_r, next_state;
  logic [HOLDOFF_BITS-1:0] hcnt_r;
  logic [NUM_PHI-1:0]      trig_phi_r;
  logic [1:0]              trig_pol_r;
  logic [15:0]             trig_count_r;
  logic                    trig, busy;

  // Pin capture, previous-sample register and rising-edge detection
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      in_v_r   <= PHI_ZERO;
      in_h_r   <= PHI_ZERO;
      prev_v_r <= PHI_ZERO;
      prev_h_r <= PHI_ZERO;
      edge_v_r <= PHI_ZERO;
      edge_h_r <= PHI_ZERO;
    end else begin
      in_v_r   <= V_pol_phi_i;
      in_h_r   <= H_pol_phi_i;
      prev_v_r <= in_v_r;
      prev_h_r <= in_h_r;
      edge_v_r <= in_v_r & ~prev_v_r;
      edge_h_r <= in_h_r & ~prev_h_r;
    end
  end

  // Per-sector window counters; a fresh edge reloads, otherwise count down to zero
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NUM_PHI; j++) begin
        cnt_v_r[j] <= CNT_ZERO;
        cnt_h_r[j] <= CNT_ZERO;
      end
    end else begin
      for (int j = 0; j < NUM_PHI; j++) begin
        if (edge_v_r[j])
          cnt_v_r[j] <= stretch_i;
        else if (cnt_v_r[j] != CNT_ZERO)
          cnt_v_r[j] <= cnt_v_r[j] - CNT_ONE;
        if (edge_h_r[j])
          cnt_h_r[j] <= stretch_i;
        else if (cnt_h_r[j] != CNT_ZERO)
          cnt_h_r[j] <= cnt_h_r[j] - CNT_ONE;
      end
    end
  end

  // Window is open on the edge cycle itself plus stretch_i further cycles
  always_comb begin
    win_v = PHI_ZERO;
    win_h = PHI_ZERO;
    for (int j = 0; j < NUM_PHI; j++) begin
      win_v[j] = edge_v_r[j] | (cnt_v_r[j] != CNT_ZERO);
      win_h[j] = edge_h_r[j] | (cnt_h_r[j] != CNT_ZERO);
    end
  end

  // Adjacent-pair coincidence; bit NUM_PHI-1 pairs with bit 0
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      pair_v_r <= PHI_ZERO;
      pair_h_r <= PHI_ZERO;
    end else begin
      pair_v_r <= win_v & {win_v[0], win_v[NUM_PHI-1:1]};
      pair_h_r <= win_h & {win_h[0], win_h[NUM_PHI-1:1]};
    end
  end

  // Polarization enables and trigger selection
  always_comb begin
    v_en   = (pol_mode_i == 2'b00) || (pol_mode_i == 2'b10);
    h_en   = (pol_mode_i == 2'b01) || (pol_mode_i == 2'b10);
    v_fire = v_en & (|pair_v_r);
    h_fire = h_en & (|pair_h_r);
    sel    = v_fire | h_fire;
  end

  // Trigger FSM state register
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i)
      state_r <= IDLE;
    else
      state_r <= next_state;
  end

  // Trigger FSM next-state logic
  always_comb begin
    next_state = state_r;
    case (state_r)
      IDLE: begin
        if (sel)
          next_state = TRIGGER;
        else
          next_state = IDLE;
      end
      TRIGGER: begin
        if (hcnt_r != HOLD_ZERO)
          next_state = HOLDOFF;
        else
          next_state = IDLE;
      end
      HOLDOFF: begin
        if (hcnt_r <= HOLD_ONE)
          next_state = IDLE;
        else
          next_state = HOLDOFF;
      end
      default: next_state = IDLE;
    endcase
  end

  // Trigger FSM outputs decoded from the registered state
  always_comb begin
    trig = 1'b0;
    busy = 1'b0;
    case (state_r)
      IDLE:    begin trig = 1'b0; busy = 1'b0; end
      TRIGGER: begin trig = 1'b1; busy = 1'b1; end
      HOLDOFF: begin trig = 1'b0; busy = 1'b1; end
      default: begin trig = 1'b0; busy = 1'b0; end
    endcase
  end

  // Holdoff counter, latched trigger pattern and saturating trigger count
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_r       <= HOLD_ZERO;
      trig_phi_r   <= PHI_ZERO;
      trig_pol_r   <= 2'b00;
      trig_count_r <= 16'h0000;
    end else begin
      if (state_r == IDLE && sel) begin
        hcnt_r     <= holdoff_i;
        trig_phi_r <= (v_en ? pair_v_r : PHI_ZERO) | (h_en ? pair_h_r : PHI_ZERO);
        trig_pol_r <= {h_fire, v_fire};
      end else if (state_r == HOLDOFF && hcnt_r != HOLD_ZERO) begin
        hcnt_r <= hcnt_r - HOLD_ONE;
      end
      if (state_r == TRIGGER && trig_count_r != 16'hFFFF)
        trig_count_r <= trig_count_r + 16'd1;
    end
  end

  assign trig_o       = trig;
  assign busy_o       = busy;
  assign trig_phi_o   = trig_phi_r;
  assign trig_pol_o   = trig_pol_r;
  assign trig_count_o = trig_count_r;

endmodule

// File: tb/tb_anita3_phi_trigger_receiver.sv
// Scoreboard bench for anita3_phi_trigger_receiver: directed pulses push expected
// triggers; a negedge monitor pops and checks each trig_o pulse and busy length.
module tb_anita3_phi_trigger_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] v_lines, h_lines;
  logic [3:0]  stretch;
  logic [7:0]  holdoff;
  logic [1:0]  pol_mode;
  logic        trig_o, busy_o;
  logic [15:0] trig_phi_o, trig_count_o;
  logic [1:0]  trig_pol_o;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count;

  typedef struct {
    int unsigned cyc;
    logic [15:0] phi;
    logic [1:0]  pol;
    logic [15:0] cnt;
    int unsigned busy;
  } exp_t;
  exp_t q[$];

  anita3_phi_trigger_receiver dut (
    .clk250_i    (clk),
    .rst_i       (rst),
    .V_pol_phi_i (v_lines),
    .H_pol_phi_i (h_lines),
    .stretch_i   (stretch),
    .holdoff_i   (holdoff),
    .pol_mode_i  (pol_mode),
    .trig_o      (trig_o),
    .trig_phi_o  (trig_phi_o),
    .trig_pol_o  (trig_pol_o),
    .busy_o      (busy_o),
    .trig_count_o(trig_count_o)
  );

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic pulse_at(input int unsigned t, input logic [15:0] v, input logic [15:0] h);
    wait_cyc(t);
    v_lines = v;
    h_lines = h;
    @(negedge clk);
    v_lines = 16'h0000;
    h_lines = 16'h0000;
  endtask

  task automatic push(input int unsigned t, input logic [15:0] phi, input logic [1:0] pol,
                      input int unsigned busy_len);
    exp_t e;
    e.cyc  = t;
    e.phi  = phi;
    e.pol  = pol;
    e.cnt  = exp_count;
    e.busy = busy_len;
    q.push_back(e);
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
  endtask

  // Monitor: every trig_o pulse must match the head of the scoreboard
  initial begin
    exp_t        e;
    int unsigned busy_run = 0;
    int unsigned cur_busy = 0;
    forever begin
      @(negedge clk);
      if (busy_o === 1'b1) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", busy_run, cur_busy);
        busy_run = 0;
      end
      if (trig_o === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_trig: trig_o=1 at cycle %0d, expected none", cyc);
        end else begin
          e = q.pop_front();
          cur_busy = e.busy;
          chk("trig_cycle", cyc, e.cyc);
          chk("trig_phi", trig_phi_o, e.phi);
          chk("trig_pol", trig_pol_o, e.pol);
          chk("trig_count", trig_count_o, e.cnt);
        end
      end
    end
  end

  initial begin
    int unsigned t;
    rst = 1'b1; v_lines = 16'h0000; h_lines = 16'h0000;
    stretch = 4'd0; holdoff = 8'd0; pol_mode = 2'b00;
    exp_count = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_trig", trig_o, 1'b0);
    chk("rst_phi", trig_phi_o, 16'h0000);
    chk("rst_pol", trig_pol_o, 2'b00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_count", trig_count_o, 16'h0000);
    rst = 1'b0;

    // Lone sector: no coincidence
    t = cyc + 2;
    pulse_at(t, 16'h0008, 16'h0000);
    wait_cyc(t + 14);
    chk("single_sector_count", trig_count_o, 16'h0000);

    // Wrap-around pair 15/0, stretch 0
    t = cyc + 2;
    push(t + 4, 16'h8000, 2'b01, 1);
    pulse_at(t, 16'h8001, 16'h0000);
    wait_cyc(t + 14);
    chk("wrap_count", trig_count_o, exp_count);

    // Stretch boundary on H: d=3 coincides, d=4 does not
    stretch = 4'd3; pol_mode = 2'b01;
    t = cyc + 2;
    push(t + 7, 16'h0020, 2'b10, 1);
    pulse_at(t, 16'h0000, 16'h0020);
    pulse_at(t + 3, 16'h0000, 16'h0040);
    wait_cyc(t + 20);
    t = cyc + 2;
    pulse_at(t, 16'h0000, 16'h0020);
    pulse_at(t + 4, 16'h0000, 16'h0040);
    wait_cyc(t + 20);
    chk("stretch_count", trig_count_o, exp_count);

    // Holdoff 10 with fresh coincidences every 4 cycles
    stretch = 4'd0; holdoff = 8'd10; pol_mode = 2'b00;
    t = cyc + 2;
    push(t + 4, 16'h0001, 2'b01, 11);
    push(t + 16, 16'h0001, 2'b01, 11);
    push(t + 28, 16'h0001, 2'b01, 11);
    for (int i = 0; i < 7; i++) pulse_at(t + 4 * i, 16'h0003, 16'h0000);
    wait_cyc(t + 50);
    chk("holdoff_count", trig_count_o, exp_count);

    // Both polarizations at 7/8 in mode 10, then disabled mode 11
    holdoff = 8'd0; pol_mode = 2'b10;
    t = cyc + 2;
    push(t + 4, 16'h0080, 2'b11, 1);
    pulse_at(t, 16'h0180, 16'h0180);
    wait_cyc(t + 14);
    pol_mode = 2'b11;
    t = cyc + 2;
    pulse_at(t, 16'h0180, 16'h0180);
    wait_cyc(t + 14);
    chk("mode_count", trig_count_o, exp_count);

    // Saturation via backdoor preload
    pol_mode = 2'b00;
    @(negedge clk);
    force dut.trig_count_r = 16'hFFFE;
    @(negedge clk);
    release dut.trig_count_r;
    exp_count = 16'hFFFE;
    t = cyc + 2;
    push(t + 4, 16'h0001, 2'b01, 1);
    pulse_at(t, 16'h0003, 16'h0000);
    wait_cyc(t + 12);
    t = cyc + 2;
    push(t + 4, 16'h0001, 2'b01, 1);
    pulse_at(t, 16'h0003, 16'h0000);
    wait_cyc(t + 12);
    chk("saturate_count", trig_count_o, 16'hFFFF);

    // Reset asserted during holdoff, then a normal trigger
    holdoff = 8'd20;
    t = cyc + 2;
    push(t + 4, 16'h0001, 2'b01, 4);
    pulse_at(t, 16'h0003, 16'h0000);
    wait_cyc(t + 7);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_trig", trig_o, 1'b0);
    chk("mid_rst_phi", trig_phi_o, 16'h0000);
    chk("mid_rst_pol", trig_pol_o, 2'b00);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_count", trig_count_o, 16'h0000);
    exp_count = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    holdoff = 8'd2;
    t = cyc + 2;
    push(t + 4, 16'h0001, 2'b01, 3);
    pulse_at(t, 16'h0003, 16'h0000);
    wait_cyc(t + 15);
    chk("post_rst_count", trig_count_o, 16'h0001);

    wait_cyc(cyc + 20);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
